// File: rtl/seq_shifter.sv
// seq_shifter: shifts a WIDTH-bit operand by amt positions (8 modes) under a start/ready/done handshake.
// One position per RUN clock by default; defining SEQ_SHIFTER_FAST_EN advances up to four positions per clock.
module seq_shifter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sout,
  output logic             carry,
  output logic             zero
);

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_LSL  = 3'b001;
  localparam logic [2:0] OP_LSR  = 3'b010;
  localparam logic [2:0] OP_ASR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_SR1  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

`ifdef SEQ_SHIFTER_FAST_EN
  localparam int STEPS = 4;
`else
  localparam int STEPS = 1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d, work_step;
  logic [WIDTH-1:0] sout_q, sout_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             carry_int_q, carry_int_d, carry_step;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             run_last;
  logic             start_shift;

  // Returns {bit shifted out, next work value} for a single-position step.
  function automatic logic [WIDTH:0] step1(input logic [2:0] o, input logic [WIDTH-1:0] w);
    logic [WIDTH:0] r;
    r = {1'b0, w};
    case (o)
      OP_LSL:  r = {w[WIDTH-1], w[WIDTH-2:0], 1'b0};
      OP_LSR:  r = {w[0], 1'b0, w[WIDTH-1:1]};
      OP_ASR:  r = {w[0], w[WIDTH-1], w[WIDTH-1:1]};
      OP_ROL:  r = {w[WIDTH-1], w[WIDTH-2:0], w[WIDTH-1]};
      OP_ROR:  r = {w[0], w[0], w[WIDTH-1:1]};
      OP_SR1:  r = {w[0], 1'b1, w[WIDTH-1:1]};
      default: r = {1'b0, w};
    endcase
    return r;
  endfunction

  assign start_shift = (amt != '0) && (op != OP_PASS) && (op != OP_RSVD);
  assign run_last    = (int'(cnt_q) <= STEPS);

  always_comb begin
    work_step  = work_q;
    carry_step = carry_int_q;
    for (int i = 0; i < STEPS; i++) begin
      if (i < int'(cnt_q)) begin
        {carry_step, work_step} = step1(op_q, work_step);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = start_shift ? S_RUN : S_DONE;
      S_RUN:   if (run_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == S_IDLE);
    done  = (state_q == S_DONE);
  end

  always_comb begin
    work_d      = work_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    carry_int_d = carry_int_q;
    sout_d      = sout_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          work_d      = in;
          cnt_d       = amt;
          op_d        = op;
          carry_int_d = 1'b0;
          if (!start_shift) begin
            sout_d  = in;
            carry_d = 1'b0;
            zero_d  = (in == '0);
          end
        end
      end
      S_RUN: begin
        work_d      = work_step;
        carry_int_d = carry_step;
        cnt_d       = run_last ? '0 : cnt_q - AMT_W'(STEPS);
        if (run_last) begin
          sout_d  = work_step;
          carry_d = carry_step;
          zero_d  = (work_step == '0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work_q      <= '0;
      cnt_q       <= '0;
      op_q        <= OP_PASS;
      carry_int_q <= 1'b0;
      sout_q      <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b1;
    end else begin
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      carry_int_q <= carry_int_d;
      sout_q      <= sout_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
    end
  end

  assign sout  = sout_q;
  assign carry = carry_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: directed scenarios plus randomized ops against an arithmetic reference model.
module tb_seq_shifter;
  localparam int W  = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    op;
  logic [AW-1:0] amt;
  logic [W-1:0]  din;
  logic          ready, done, carry, zero;
  logic [W-1:0]  sout;

  int errors = 0;
  int checks = 0;

  seq_shifter #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .amt(amt), .in(din),
    .ready(ready), .done(done), .sout(sout), .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  // Reference result from the shift definitions, with saturation/wrap for amounts >= W.
  function automatic void model(input logic [2:0] o, input int a, input logic [W-1:0] d,
                                output logic [W-1:0] r, output logic c);
    logic signed [W-1:0] s;
    logic [W-1:0] ones;
    int k;
    ones = '1;
    r = d;
    c = 1'b0;
    k = a % W;
    if (a == 0 || o == 3'b000 || o == 3'b111) return;
    case (o)
      3'b001: begin r = d << a; c = (a <= W) ? d[W-a] : 1'b0; end
      3'b010: begin r = d >> a; c = (a <= W) ? d[a-1] : 1'b0; end
      3'b011: begin s = d; s = s >>> a; r = s; c = (a <= W) ? d[a-1] : d[W-1]; end
      3'b100: begin r = (k == 0) ? d : ((d << k) | (d >> (W - k))); c = r[0]; end
      3'b101: begin r = (k == 0) ? d : ((d >> k) | (d << (W - k))); c = r[W-1]; end
      default: begin r = (d >> a) | ~(ones >> a); c = (a <= W) ? d[a-1] : 1'b1; end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input int a);
    if (a == 0 || o == 3'b000 || o == 3'b111) return 1;
`ifdef SEQ_SHIFTER_FAST_EN
    return (a + 3) / 4 + 1;
`else
    return a + 1;
`endif
  endfunction

  // Issues one op and returns edges from the start edge (counted as 1) to the done cycle.
  task automatic do_op(input logic [2:0] o, input int a, input logic [W-1:0] d, output int cyc);
    @(negedge clk);
    while (!ready) @(negedge clk);
    start = 1'b1; op = o; amt = AW'(a); din = d;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); amt = AW'($urandom); din = W'($urandom);
    cyc = 1;
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = '0; amt = '0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL reset_hs: ready=%b done=%b expected 1/0", ready, done); end
    checks++; if (sout !== 16'h0000 || zero !== 1'b1 || carry !== 1'b0) begin errors++; $display("FAIL reset_res: sout=%h zero=%b carry=%b expected 0000/1/0", sout, zero, carry); end
    @(negedge clk); reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b1 || done !== 1'b0 || sout !== 16'h0000) begin errors++; $display("FAIL idle_after_reset: ready=%b done=%b sout=%h expected 1/0/0000", ready, done, sout); end
  endtask

  task automatic test_lsl_latency;
    int cyc, lat;
`ifdef SEQ_SHIFTER_FAST_EN
    lat = 2;
`else
    lat = 5;
`endif
    do_op(3'b001, 4, 16'h0001, cyc);
    checks++; if (cyc !== lat) begin errors++; $display("FAIL lsl_latency: got %0d expected %0d", cyc, lat); end
    checks++; if (sout !== 16'h0010 || carry !== 1'b0 || zero !== 1'b0) begin errors++; $display("FAIL lsl_result: sout=%h carry=%b zero=%b expected 0010/0/0", sout, carry, zero); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || ready !== 1'b1 || sout !== 16'h0010) begin errors++; $display("FAIL done_pulse: done=%b ready=%b sout=%h expected 0/1/0010", done, ready, sout); end
  endtask

  task automatic test_asr_ror;
    int cyc;
    do_op(3'b011, 2, 16'h8004, cyc);
    checks++; if (sout !== 16'hE001 || carry !== 1'b0 || cyc !== exp_lat(3'b011, 2)) begin errors++; $display("FAIL asr: sout=%h carry=%b lat=%0d expected E001/0/%0d", sout, carry, cyc, exp_lat(3'b011, 2)); end
    do_op(3'b101, 1, 16'h0003, cyc);
    checks++; if (sout !== 16'h8001 || carry !== 1'b1 || cyc !== exp_lat(3'b101, 1)) begin errors++; $display("FAIL ror: sout=%h carry=%b lat=%0d expected 8001/1/%0d", sout, carry, cyc, exp_lat(3'b101, 1)); end
  endtask

  task automatic test_sr1_lsr;
    int cyc, lat;
`ifdef SEQ_SHIFTER_FAST_EN
    lat = 5;
`else
    lat = 16;
`endif
    do_op(3'b110, 3, 16'h0000, cyc);
    checks++; if (sout !== 16'hE000 || zero !== 1'b0) begin errors++; $display("FAIL sr1: sout=%h zero=%b expected E000/0", sout, zero); end
    do_op(3'b010, 15, 16'h8000, cyc);
    checks++; if (sout !== 16'h0001 || carry !== 1'b0) begin errors++; $display("FAIL lsr15: sout=%h carry=%b expected 0001/0", sout, carry); end
    checks++; if (cyc !== lat) begin errors++; $display("FAIL lsr15_latency: got %0d expected %0d", cyc, lat); end
    do_op(3'b010, 20, 16'hFFFF, cyc);
    checks++; if (sout !== 16'h0000 || zero !== 1'b1 || carry !== 1'b0) begin errors++; $display("FAIL lsr_sat: sout=%h zero=%b carry=%b expected 0000/1/0", sout, zero, carry); end
  endtask

  task automatic test_amt0_ignore;
    int cyc, pulses, lat;
    logic [W-1:0] got, er;
    logic gc, ec;
    do_op(3'b001, 0, 16'hABCD, cyc);
    checks++; if (cyc !== 1 || sout !== 16'hABCD || carry !== 1'b0) begin errors++; $display("FAIL amt0: lat=%0d sout=%h carry=%b expected 1/ABCD/0", cyc, sout, carry); end
    @(negedge clk);
    while (!ready) @(negedge clk);
    start = 1'b1; op = 3'b101; amt = AW'(7); din = 16'h00F1;
    pulses = 0; lat = 0; got = '0; gc = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      start = (c == 2);
      if (c == 2) begin op = 3'b001; amt = AW'(3); din = 16'hFFFF; end
      if (done) begin pulses++; lat = c; got = sout; gc = carry; end
    end
    model(3'b101, 7, 16'h00F1, er, ec);
    checks++; if (pulses !== 1) begin errors++; $display("FAIL ignore_pulses: got %0d expected 1", pulses); end
    checks++; if (got !== er || gc !== ec || lat !== exp_lat(3'b101, 7)) begin errors++; $display("FAIL ignore_result: sout=%h carry=%b lat=%0d expected %h/%b/%0d", got, gc, lat, er, ec, exp_lat(3'b101, 7)); end
  endtask

  task automatic test_reset_mid;
    int cyc, saw;
    @(negedge clk);
    while (!ready) @(negedge clk);
    start = 1'b1; op = 3'b100; amt = AW'(8); din = 16'h1234;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checks++; if (ready !== 1'b1 || done !== 1'b0 || sout !== 16'h0000 || zero !== 1'b1 || carry !== 1'b0) begin errors++; $display("FAIL mid_reset: ready=%b done=%b sout=%h zero=%b carry=%b expected 1/0/0000/1/0", ready, done, sout, zero, carry); end
    @(negedge clk); reset = 1'b0;
    saw = 0;
    repeat (12) begin @(posedge clk); #1; if (done) saw++; end
    checks++; if (saw !== 0) begin errors++; $display("FAIL abandoned_done: got %0d pulses expected 0", saw); end
    do_op(3'b100, 8, 16'h1234, cyc);
    checks++; if (sout !== 16'h3412 || cyc !== exp_lat(3'b100, 8)) begin errors++; $display("FAIL rol8: sout=%h lat=%0d expected 3412/%0d", sout, cyc, exp_lat(3'b100, 8)); end
  endtask

  task automatic test_random;
    int cyc, a;
    logic [2:0] o;
    logic [W-1:0] d, er;
    logic ec;
    for (int n = 0; n < 60; n++) begin
      o = 3'($urandom);
      a = int'($urandom_range(0, 31));
      d = W'($urandom);
      if (n % 8 == 0) d = '0;
      model(o, a, d, er, ec);
      do_op(o, a, d, cyc);
      checks++;
      if (sout !== er || carry !== ec || zero !== (er == '0) || cyc !== exp_lat(o, a)) begin
        errors++;
        $display("FAIL rand op=%0d amt=%0d in=%h: sout=%h carry=%b zero=%b lat=%0d expected %h/%b/%b/%0d",
                 o, a, d, sout, carry, zero, cyc, er, ec, (er == '0), exp_lat(o, a));
      end
    end
  endtask

  initial begin
    test_reset;
    test_lsl_latency;
    test_asr_ror;
    test_sr1_lsr;
    test_amt0_ignore;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
- Multi-cycle, parametrised successor to the datapath's 16-bit single-step shifter.
- Shifts a WIDTH-bit operand by a run-time amount using one of eight modes: logical, arithmetic, rotate and fill-with-one.
- Moves one bit position per clock under a start/done handshake.
- Sits between the register file read port and the ALU, and is used for multi-bit shift instructions.

Parameters:
- WIDTH, 16, operand/result width in bits (>=2)
- AMT_W, 4, width of shift-amount input; amounts 0..2^AMT_W-1 accepted

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only when ready=1
- op  input  3  mode, sampled with start
- amt  input  AMT_W  shift count, sampled with start
- in  input  WIDTH  operand, sampled with start
- ready  output  1  high in IDLE only
- done  output  1  one-cycle pulse: sout/carry/zero updated
- sout  output  WIDTH  result register
- carry  output  1  last bit shifted/rotated out
- zero  output  1  sout==0

Behaviour:
- Reset (async, any state): state=IDLE, sout=0, carry=0, zero=1, done=0, ready=1, internal work/count=0. Reset mid-operation abandons the operation; no done is produced.
- op encoding:
  - 000 pass
  - 001 LSL (fill 0)
  - 010 LSR (fill 0)
  - 011 ASR (fill MSB)
  - 100 ROL
  - 101 ROR
  - 110 SR1 (right, fill 1)
  - 111 reserved, behaves as pass
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge: work<=in, cnt<=amt, op latched, carry_int<=0.
  - Next state RUN if amt!=0 and op not pass/reserved.
  - Otherwise next state DONE.
- RUN: each edge applies one single-bit step of latched op to work, carry_int<=bit leaving work, cnt<=cnt-1. When cnt==1 at the edge, next state DONE.
- DONE (one cycle): done=1; sout, carry, zero present the final result; next state IDLE.
  - sout/carry/zero are loaded on the edge entering DONE.
  - They hold until the next DONE entry or reset.
- Latency: done high in the cycle beginning N+1 edges after the start edge, where N=amt for shifting ops and N=0 for pass/reserved or amt=0.
- amt=0 or pass: sout=in, carry=0.
- amt>=WIDTH is legal and iterates amt steps:
  - LSL/LSR saturate to 0.
  - ASR saturates to all-MSB.
  - SR1 saturates to all-ones.
  - Rotates wrap modulo WIDTH.
- start while ready=0 (RUN or DONE) is ignored entirely; inputs are not re-sampled.
- op/amt/in may change freely after the start edge.

Optional Feature:
- Macro: SEQ_SHIFTER_FAST_EN
- Defined: each RUN edge advances min(cnt,4) positions; cnt decrements by that amount; RUN exits when the step consumes the remaining cnt.
  - Results, carry and zero are identical to the non-fast build.
  - Latency N becomes ceil(amt/4).
- Not defined: one position per edge as above.

Test Plan:
- Reset then idle -> ready=1, done=0, sout=16'h0000, zero=1, carry=0.
- op=LSL, in=16'h0001, amt=4 -> done 5 cycles after start edge, sout=16'h0010, carry=0, zero=0; with SEQ_SHIFTER_FAST_EN, done 2 cycles after.
- op=ASR, in=16'h8004, amt=2 -> sout=16'hE001, carry=0. Then op=ROR, in=16'h0003, amt=1 -> sout=16'h8001, carry=1.
- op=SR1, in=16'h0000, amt=3 -> sout=16'hE000. Then op=LSR, in=16'h8000, amt=15 -> sout=16'h0001, carry=0; done at 16 cycles (fast build: 5).
- op=LSL, in=16'hABCD, amt=0 -> done 1 cycle after start, sout=16'hABCD, carry=0. A second start pulsed during a 7-step run -> ignored, exactly one done pulse observed.
- Start ROL in=16'h1234 amt=8, assert reset after 3 cycles -> immediate IDLE, sout=0, zero=1, no done. Next op=ROL, in=16'h1234, amt=8 -> sout=16'h3412.
